// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the multiplier / MAC datapath:
//   PROD_W   - width of the unsigned product emitted by the 8x8 multiplier
//   state_t  - two-state frame FSM encoding used by product_accumulator
//   sat_max  - all-ones value of a given width, used as a saturation ceiling
package mult_pkg;

  localparam int PROD_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Largest unsigned value representable in w bits (w <= 63).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder
// Unsigned saturating adder: sum = min(a + b, 2^W - 1).
// Ports:
//   a    in  [W-1:0]       running accumulator value
//   b    in  [PROD_W-1:0]  product to add (zero-extended)
//   sum  out [W-1:0]       saturated sum
//   ovf  out               true sum exceeded 2^W - 1
module sat_adder
  import mult_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]      a,
  input  logic [PROD_W-1:0] b,
  output logic [W-1:0]      sum,
  output logic              ovf
);

  // One guard bit: a single W-bit + 16-bit add (W >= 16) can carry out at
  // most one bit, so the adder MSB alone is the overflow indication.
  function automatic logic [W:0] add_wide(input logic [W-1:0] x,
                                          input logic [PROD_W-1:0] y);
    return {1'b0, x} + (W+1)'(y);
  endfunction

  function automatic logic [W-1:0] saturate(input logic [W:0] s);
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  logic [W:0] sum_full;

  assign sum_full = add_wide(a, b);
  assign ovf      = sum_full[W];
  assign sum      = saturate(sum_full);

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a stream of unsigned multiplier products into a saturating ACC_W-bit
// accumulator. The beat flagged last latches the frame total, beat count and
// overflow flag into held output registers and the block waits in HOLD until
// the result is taken.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   product beat valid
//   in_ready   out  block can accept a beat (high in ACCUM)
//   in_prod    in   [15:0] unsigned product
//   in_last    in   final beat of the frame
//   out_valid  out  frame result held (high in HOLD)
//   out_ready  in   downstream takes the result
//   out_sum    out  [ACC_W-1:0] saturated frame sum
//   out_count  out  [LEN_W-1:0] beats in frame, saturating
//   out_ovf    out  accumulator saturated during the frame
module product_accumulator
  import mult_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(sat_max(LEN_W));

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   acc_nxt;
  logic               add_ovf;
  logic [LEN_W-1:0]   cnt_nxt;
  logic               ovf_nxt;
  logic               accept;

  // Handshake decode straight from the state register: no input-to-output
  // or out_ready-to-in_ready combinational path.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  sat_adder #(.W(ACC_W)) u_sat_adder (
    .a   (acc_q),
    .b   (in_prod),
    .sum (acc_nxt),
    .ovf (add_ovf)
  );

  assign cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);
  assign ovf_nxt = ovf_q | add_ovf;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && in_last) state_d = HOLD;
      HOLD:  if (out_ready)         state_d = ACCUM;
      default:                      state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulate stage: running totals, cleared once a frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_nxt;
        ovf_q <= ovf_nxt;
      end
    end
  end

  // Result stage: loaded with the post-update totals of the last beat and
  // held untouched through HOLD and the following ACCUM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept && in_last) begin
      out_sum   <= acc_nxt;
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int ACC_W = 24;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             out_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents a beat, waits (bounded) for in_ready, lets
  // the next posedge accept it, and returns at the following negedge.
  task automatic send_beat(input logic [15:0] p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] s,
                              input logic [31:0] c, input logic o);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"},   {8'd0, out_sum},    s);
    check({tag, "_count"}, {24'd0, out_count}, c);
    check({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, o});
  endtask

  // Called at a negedge while in HOLD; takes the result in one cycle.
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released_ready"}, {31'd0, in_ready},  32'd1);
    check({tag, "_released_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Back-to-back stimulus table and monitor state.
  logic [15:0] b2b_val [8] = '{16'd10, 16'd20, 16'd30, 16'd65535,
                               16'd1, 16'd2, 16'd3, 16'd4};
  logic        b2b_lst [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] exp_sum [3];
  logic [31:0] exp_cnt [3];
  logic        mon_en = 1'b0;
  int          frames_seen = 0;
  int          ready_low = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!in_ready) ready_low++;
      if (out_valid) begin
        if (frames_seen < 3) begin
          check("b2b_sum",   {8'd0, out_sum},    exp_sum[frames_seen]);
          check("b2b_count", {24'd0, out_count}, exp_cnt[frames_seen]);
        end
        frames_seen++;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   {8'd0, out_sum},    32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-beat frame of 65025
    send_beat(16'd65025, 1'b0);
    check("f3_mid_valid", {31'd0, out_valid}, 32'd0);
    send_beat(16'd65025, 1'b0);
    send_beat(16'd65025, 1'b1);
    check_result("f3", 32'd195075, 32'd3, 1'b0);
    check("f3_hold_ready", {31'd0, in_ready}, 32'd0);
    take_result("f3");

    // 259 beats of 65025: sum and count both saturate
    for (int i = 0; i < 259; i++) send_beat(16'd65025, (i == 258));
    check_result("sat", 32'd16777215, 32'd255, 1'b1);
    take_result("sat");
    send_beat(16'd5, 1'b1);
    check_result("clean", 32'd5, 32'd1, 1'b0);
    take_result("clean");

    // Single zero-valued beat
    send_beat(16'd0, 1'b1);
    check_result("zero", 32'd0, 32'd1, 1'b0);
    take_result("zero");

    // Back-pressure in HOLD, with a beat offered during HOLD
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b1);
    in_valid = 1'b1;
    in_prod  = 16'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_result("hold", 32'd300, 32'd2, 1'b0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release_valid", {31'd0, out_valid}, 32'd0);
    check("hold_release_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("held_beat", 32'd9, 32'd1, 1'b0);
    take_result("held_beat");

    // Asynchronous reset mid-frame
    send_beat(16'd1000, 1'b0);
    send_beat(16'd1000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_sum",   {8'd0, out_sum},    32'd0);
    check("arst_out_count", {24'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(16'd7, 1'b1);
    check_result("post_rst", 32'd7, 32'd1, 1'b0);
    take_result("post_rst");

    // Back-to-back frames, out_ready tied high, reference sums from the table
    begin
      int f;
      f = 0;
      exp_sum = '{32'd0, 32'd0, 32'd0};
      exp_cnt = '{32'd0, 32'd0, 32'd0};
      for (int i = 0; i < 8; i++) begin
        exp_sum[f] += {16'd0, b2b_val[i]};
        exp_cnt[f] += 32'd1;
        if (b2b_lst[i]) f++;
      end
    end
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(b2b_val[i], b2b_lst[i]);
    @(negedge clk);
    mon_en = 1'b0;
    out_ready = 1'b0;
    check("b2b_frames",    frames_seen, 32'd3);
    check("b2b_ready_low", ready_low,   32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
